// File: rtl/serial_pe.sv
// rtl/serial_pe.sv - serial int16 multiply-accumulate element
// Stage 1 registers the product with its ctl, stage 2 accumulates and publishes completed dot products.

module serial_pe (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] neuron,
  input  logic signed [15:0] weight,
  input  logic        [1:0]  ctl,
  input  logic               vld_i,
  output logic signed [31:0] result,
  output logic               vld_o
);

  logic signed [31:0] prod;
  logic signed [31:0] prod_q;
  logic        [1:0]  ctl_q;
  logic               vld_q;
  logic signed [31:0] acc;
  logic signed [31:0] sum;

  assign prod = neuron * weight;

  // ctl is masked by vld_i so an idle cycle can never carry a stray first/last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      ctl_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_i;
      ctl_q <= vld_i ? ctl : 2'b00;
      if (vld_i) prod_q <= prod;
    end
  end

  // a first element restarts the sum, so back-to-back vectors never see the old total
  assign sum = ctl_q[0] ? prod_q : acc + prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld_q & ctl_q[1];
      if (vld_q) begin
        acc <= sum;
        if (ctl_q[1]) result <= sum;
      end
    end
  end

endmodule

// File: tb/tb_serial_pe.sv
// tb/tb_serial_pe.sv - directed self-checking bench for serial_pe

module tb_serial_pe;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] neuron;
  logic signed [15:0] weight;
  logic        [1:0]  ctl;
  logic               vld_i;
  logic signed [31:0] result;
  logic               vld_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  serial_pe dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .neuron (neuron),
    .weight (weight),
    .ctl    (ctl),
    .vld_i  (vld_i),
    .result (result),
    .vld_o  (vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (vld_o) got_q.push_back(result);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic signed [15:0] n, input logic signed [15:0] w, input logic [1:0] c);
    neuron = n;
    weight = w;
    ctl    = c;
    vld_i  = 1'b1;
    @(posedge clk);
    #1;
    vld_i  = 1'b0;
    ctl    = 2'b00;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // compares every captured pulse against the expected list, then empties both
  task automatic drain(input string tag);
    idle(4);
    check({tag, "_pulses"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_res%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int model;
    int len;
    logic [31:0] r;
    logic signed [15:0] a;
    logic signed [15:0] b;

    rst_n  = 1'b0;
    neuron = '0;
    weight = '0;
    ctl    = 2'b00;
    vld_i  = 1'b0;
    idle(3);
    check("rst_result", result, 32'd0);
    check("rst_vld_o", {31'd0, vld_o}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 32 x (1*2) with explicit latency probing
    for (int i = 0; i < 32; i++)
      send(16'sd1, 16'sd2, {i == 31, i == 0});
    @(negedge clk);
    check("lat_edge_n", {31'd0, vld_o}, 32'd0);
    @(negedge clk);
    check("lat_edge_n1", {31'd0, vld_o}, 32'd1);
    check("lat_result", result, 32'd64);
    @(negedge clk);
    check("lat_pulse_end", {31'd0, vld_o}, 32'd0);
    exp_q.push_back(32'd64);
    drain("vec32");

    // signed operands
    send(-16'sd3, 16'sd5, 2'b01);
    send(16'sd7, -16'sd2, 2'b10);
    exp_q.push_back(32'hFFFFFFE3);
    drain("signed");

    // idle gaps inside a vector
    send(16'sd2, 16'sd3, 2'b01);
    idle(3);
    send(16'sd4, 16'sd5, 2'b10);
    exp_q.push_back(32'd26);
    drain("gaps");

    // four back-to-back vectors of 32*k elements against a bench model
    for (int k = 1; k <= 4; k++) begin
      len = 32 * k;
      model = 0;
      for (int i = 0; i < len; i++) begin
        r = $urandom;
        a = r[15:0];
        b = r[31:16];
        model = model + int'(a) * int'(b);
        send(a, b, {i == len - 1, i == 0});
      end
      exp_q.push_back(model);
    end
    drain("b2b");

    // single-element vector, then a short one right behind it
    send(-16'sd32768, -16'sd32768, 2'b11);
    send(16'sd100, 16'sd100, 2'b01);
    send(16'sd1, 16'sd1, 2'b10);
    exp_q.push_back(32'h40000000);
    exp_q.push_back(32'd10001);
    drain("single");

    // wraparound: 3 * 0x3FFF0001 mod 2^32
    send(16'sd32767, 16'sd32767, 2'b01);
    send(16'sd32767, 16'sd32767, 2'b00);
    send(16'sd32767, 16'sd32767, 2'b10);
    exp_q.push_back(32'hBFFD0003);
    drain("wrap");

    // reset while the closing element is still in stage 1
    send(16'sd3, 16'sd3, 2'b01);
    send(16'sd4, 16'sd4, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_vld_o", {31'd0, vld_o}, 32'd0);
    idle(2);
    check("mid_rst_hold", result, 32'd0);
    rst_n = 1'b1;
    send(16'sd1, 16'sd1, 2'b01);
    send(16'sd1, 16'sd1, 2'b10);
    exp_q.push_back(32'd2);
    drain("abort");

    // element without ctl[0] after reset accumulates onto zero
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    send(16'sd5, 16'sd5, 2'b10);
    exp_q.push_back(32'd25);
    drain("no_first");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
